// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access unit.
package mem_access_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byte_en;
    } mem_req_t;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = lane[0];
            SIZE_WORD: mis = (lane != 2'b00);
            default:   mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/ready bus between the MEM-stage access unit and data memory.
interface mem_access_unit_if;

    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemByteEn;
    logic        MemReady;
    logic [31:0] MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData, MemByteEn,
        input  MemReady, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData, MemByteEn,
        output MemReady, MemRData
    );

endinterface

// File: rtl/mem_load_align.sv
// Selects a byte/half lane from a 32-bit word and sign- or zero-extends it.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_lane)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_size)
            SIZE_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues req/ready accesses, stalls upstream while
// outstanding, and hands aligned load data plus gated WB controls to MEM/WB.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic [1:0]  MemSizeIn,
    input  logic        LoadUnsignedIn,
    input  logic [31:0] ALUResultIn,
    input  logic [31:0] WriteDataIn,
    input  logic        RegWriteIn,
    input  logic        MemtoRegIn,
    input  logic [4:0]  DestinationRegisterIn,
    mem_access_unit_if.master mem_bus,
    output logic        Stall,
    output logic [31:0] ReadDataMemoryOut,
    output logic [31:0] ALUResultOut,
    output logic        RegWriteOut,
    output logic        MemtoRegOut,
    output logic [4:0]  DestinationRegisterOut,
    output logic        AddrError,
    output logic        BusError
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    mem_req_t             r_req, w_req_nxt;
    logic                 r_req_valid, w_req_valid_nxt;
    logic [31:0]          r_rdata, w_rdata_nxt;
    logic                 r_bus_error, w_bus_error_nxt;
    logic [1:0]           r_lane, w_lane_nxt;
    logic [1:0]           r_size, w_size_nxt;
    logic                 r_unsigned, w_unsigned_nxt;
    logic                 r_is_load, w_is_load_nxt;

    logic        w_access;
    logic        w_misaligned;
    logic        w_in_idle;
    logic        w_start;
    logic [31:0] w_load_data;
    logic [31:0] w_store_trunc;
    logic [31:0] w_store_wdata;
    logic [3:0]  w_store_be;

    assign w_access     = MemReadIn | MemWriteIn;
    assign w_misaligned = is_misaligned(MemSizeIn, ALUResultIn[1:0]);
    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_start      = w_in_idle & w_access & ~w_misaligned;

    // No access may be in flight or starting while reset is held.
    assign Stall     = ~Reset & (w_start | (r_state == ST_REQ));
    assign AddrError = w_in_idle & w_access & w_misaligned;

    assign RegWriteOut = RegWriteIn & ~Stall & ~AddrError & ~r_bus_error & ~Reset;
    assign MemtoRegOut = MemtoRegIn & ~Stall & ~AddrError & ~r_bus_error & ~Reset;
    assign ALUResultOut           = ALUResultIn;
    assign DestinationRegisterOut = DestinationRegisterIn;
    assign ReadDataMemoryOut      = r_rdata;
    assign BusError               = r_bus_error;

    assign mem_bus.MemReq    = r_req_valid;
    assign mem_bus.MemWe     = r_req.we;
    assign mem_bus.MemAddr   = r_req.addr;
    assign mem_bus.MemWData  = r_req.wdata;
    assign mem_bus.MemByteEn = r_req.byte_en;

    mem_load_align u_load_align (
        .i_rdata    (mem_bus.MemRData),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // Lane 0, zero-extended: truncates store data to the access size before replication.
    mem_load_align u_store_trunc (
        .i_rdata    (WriteDataIn),
        .i_lane     (2'b00),
        .i_size     (MemSizeIn),
        .i_unsigned (1'b1),
        .o_data     (w_store_trunc)
    );

    always_comb begin
        w_store_be    = 4'b1111;
        w_store_wdata = w_store_trunc;
        case (MemSizeIn)
            SIZE_BYTE: begin
                w_store_be    = 4'b0001 << ALUResultIn[1:0];
                w_store_wdata = {4{w_store_trunc[7:0]}};
            end
            SIZE_HALF: begin
                w_store_be    = ALUResultIn[1] ? 4'b1100 : 4'b0011;
                w_store_wdata = {2{w_store_trunc[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_nxt       = r_req;
        w_req_valid_nxt = r_req_valid;
        w_rdata_nxt     = r_rdata;
        w_bus_error_nxt = 1'b0;
        w_lane_nxt      = r_lane;
        w_size_nxt      = r_size;
        w_unsigned_nxt  = r_unsigned;
        w_is_load_nxt   = r_is_load;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start) begin
                    w_req_valid_nxt   = 1'b1;
                    w_req_nxt.we      = MemWriteIn;
                    w_req_nxt.addr    = {ALUResultIn[31:2], 2'b00};
                    w_req_nxt.wdata   = w_store_wdata;
                    w_req_nxt.byte_en = w_store_be;
                    w_lane_nxt        = ALUResultIn[1:0];
                    w_size_nxt        = MemSizeIn;
                    w_unsigned_nxt    = LoadUnsignedIn;
                    w_is_load_nxt     = ~MemWriteIn;
                    w_state_nxt       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_bus.MemReady) begin
                    w_req_valid_nxt = 1'b0;
                    if (r_is_load) w_rdata_nxt = w_load_data;
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_req_valid_nxt = 1'b0;
                    w_bus_error_nxt = 1'b1;
                    if (r_is_load) w_rdata_nxt = '0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = CNT_WIDTH'(r_cnt + 1'b1);
                end
            end
            ST_RESP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req       <= '0;
            r_req_valid <= 1'b0;
            r_rdata     <= '0;
            r_bus_error <= 1'b0;
            r_lane      <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_is_load   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req       <= w_req_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_rdata     <= w_rdata_nxt;
            r_bus_error <= w_bus_error_nxt;
            r_lane      <= w_lane_nxt;
            r_size      <= w_size_nxt;
            r_unsigned  <= w_unsigned_nxt;
            r_is_load   <= w_is_load_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle compare against a cycle-indexed
// behavioural model, plus hand-computed literal expectations per operation.
module tb_mem_access_unit;

    localparam int unsigned T = 4;

    logic        Clk;
    logic        Reset;
    logic        MemReadIn, MemWriteIn, LoadUnsignedIn, RegWriteIn, MemtoRegIn;
    logic [1:0]  MemSizeIn;
    logic [31:0] ALUResultIn, WriteDataIn;
    logic [4:0]  DestinationRegisterIn;
    logic        Stall, RegWriteOut, MemtoRegOut, AddrError, BusError;
    logic [31:0] ReadDataMemoryOut, ALUResultOut;
    logic [4:0]  DestinationRegisterOut;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) dut (
        .Clk                    (Clk),
        .Reset                  (Reset),
        .MemReadIn              (MemReadIn),
        .MemWriteIn             (MemWriteIn),
        .MemSizeIn              (MemSizeIn),
        .LoadUnsignedIn         (LoadUnsignedIn),
        .ALUResultIn            (ALUResultIn),
        .WriteDataIn            (WriteDataIn),
        .RegWriteIn             (RegWriteIn),
        .MemtoRegIn             (MemtoRegIn),
        .DestinationRegisterIn  (DestinationRegisterIn),
        .mem_bus                (bus),
        .Stall                  (Stall),
        .ReadDataMemoryOut      (ReadDataMemoryOut),
        .ALUResultOut           (ALUResultOut),
        .RegWriteOut            (RegWriteOut),
        .MemtoRegOut            (MemtoRegOut),
        .DestinationRegisterOut (DestinationRegisterOut),
        .AddrError              (AddrError),
        .BusError               (BusError)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wd, rdata;
        int          ready_at;          // REQ cycle (1-based) carrying MemReady; 0 = never
        logic        regw, m2r;
        logic [4:0]  dest;
        int          lit_req, lit_stall;
        logic [31:0] lit_rd;
        logic [3:0]  lit_be;            // 0 = no store-lane literal for this op
        logic [31:0] lit_wd;
        logic        lit_rw, lit_berr;
    } op_t;

    op_t ops[$];
    int  n_cmp = 0;
    int  n_err = 0;

    // Model state: k counts cycles since the op was presented (k=0 is its first cycle).
    op_t         m_cur;
    bit          m_active = 1'b0;
    int          m_k, m_nreq;
    bit          m_access, m_aligned, m_timeout;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [31:0] d, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int sh;
        if (sz == 2'd2) begin
            sh = 8 * int'(a[1:0]);
            v  = (d >> sh) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            sh = 16 * int'(a[1]);
            v  = (d >> sh) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic bit bad_align(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd2) return 1'b0;
        if (sz == 2'd1) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                               input int rdy, input logic rw, input logic [4:0] dest,
                               input int lreq, input int lstall, input logic [31:0] lrd,
                               input logic [3:0] lbe, input logic [31:0] lwd,
                               input logic lrw, input logic lberr);
        op_t o;
        o.rd = rd; o.wr = wr; o.size = sz; o.uns = uns; o.addr = addr; o.wd = wd; o.rdata = rdata;
        o.ready_at = rdy; o.regw = rw; o.m2r = rd; o.dest = dest;
        o.lit_req = lreq; o.lit_stall = lstall; o.lit_rd = lrd; o.lit_be = lbe; o.lit_wd = lwd;
        o.lit_rw = lrw; o.lit_berr = lberr;
        return o;
    endfunction

    // Per-cycle compare against the model.
    bit          e_stall, e_req, e_aerr, e_berr, e_wb;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    int          lane_i;
    always @(negedge Clk) begin
        if (m_active) begin
            e_stall = m_aligned && (m_k <= m_nreq);
            e_req   = m_aligned && (m_k >= 1) && (m_k <= m_nreq);
            e_aerr  = m_access && !m_aligned && (m_k == 0);
            e_berr  = m_timeout && (m_k == m_nreq + 1);
            e_wb    = m_aligned ? ((m_k == m_nreq + 1) && !m_timeout) : !m_access;
            chk("Stall",       32'(Stall),       32'(e_stall));
            chk("MemReq",      32'(bus.MemReq),  32'(e_req));
            chk("AddrError",   32'(AddrError),   32'(e_aerr));
            chk("BusError",    32'(BusError),    32'(e_berr));
            chk("RegWriteOut", 32'(RegWriteOut), 32'(m_cur.regw && e_wb));
            chk("MemtoRegOut", 32'(MemtoRegOut), 32'(m_cur.m2r && e_wb));
            chk("ReadData",    ReadDataMemoryOut, m_rdata);
            chk("ALUResultOut", ALUResultOut,    m_cur.addr);
            chk("DestRegOut",  32'(DestinationRegisterOut), 32'(m_cur.dest));
            if (e_req) begin
                chk("MemAddr", bus.MemAddr, m_cur.addr & 32'hFFFF_FFFC);
                chk("MemWe",   32'(bus.MemWe), 32'(m_cur.wr));
                if (m_cur.wr) begin
                    lane_i = int'(m_cur.addr[1:0]);
                    if (m_cur.size == 2'd2) begin
                        e_be = 4'(1 << lane_i);
                        e_wd = 32'(m_cur.wd[7:0]) * 32'h0101_0101;
                    end else if (m_cur.size == 2'd1) begin
                        e_be = 4'(3 << lane_i);
                        e_wd = 32'(m_cur.wd[15:0]) * 32'h0001_0001;
                    end else begin
                        e_be = 4'hF;
                        e_wd = m_cur.wd;
                    end
                    chk("MemByteEn", 32'(bus.MemByteEn), 32'(e_be));
                    chk("MemWData",  bus.MemWData, e_wd);
                end
            end
        end
    end

    task automatic run_op(input op_t op);
        int          total, cap_req, cap_stall;
        logic [3:0]  cap_be;
        logic [31:0] cap_wd;
        logic        cap_rw, cap_berr;
        MemReadIn = op.rd; MemWriteIn = op.wr; MemSizeIn = op.size; LoadUnsignedIn = op.uns;
        ALUResultIn = op.addr; WriteDataIn = op.wd; RegWriteIn = op.regw; MemtoRegIn = op.m2r;
        DestinationRegisterIn = op.dest; bus.MemRData = op.rdata; bus.MemReady = 1'b0;
        m_cur     = op;
        m_access  = op.rd | op.wr;
        m_aligned = m_access && !bad_align(op.size, op.addr);
        m_timeout = m_aligned && (op.ready_at == 0 || op.ready_at > int'(T));
        m_nreq    = !m_aligned ? 0 : (m_timeout ? int'(T) : op.ready_at);
        total     = m_aligned ? m_nreq + 2 : 1;
        cap_req = 0; cap_stall = 0; cap_be = '0; cap_wd = '0; cap_rw = 1'b0; cap_berr = 1'b0;
        for (int k = 0; k < total; k++) begin
            m_k = k;
            if (m_aligned && k == m_nreq + 1 && op.rd && !op.wr)
                m_rdata = m_timeout ? 32'h0 : ext_load(op.rdata, op.addr, op.size, op.uns);
            bus.MemReady = (op.ready_at != 0) && (k == op.ready_at);
            m_active = 1'b1;
            @(negedge Clk);
            if (Stall) cap_stall++;
            if (bus.MemReq) begin
                cap_req++;
                cap_be = bus.MemByteEn;
                cap_wd = bus.MemWData;
            end
            if (BusError) cap_berr = 1'b1;
            cap_rw = RegWriteOut;
            @(posedge Clk);
            #1;
        end
        bus.MemReady = 1'b0;
        chk("lit_req_cycles",   32'(cap_req),   32'(op.lit_req));
        chk("lit_stall_cycles", 32'(cap_stall), 32'(op.lit_stall));
        chk("lit_read_data",    ReadDataMemoryOut, op.lit_rd);
        chk("lit_regwrite",     32'(cap_rw),    32'(op.lit_rw));
        chk("lit_bus_error",    32'(cap_berr),  32'(op.lit_berr));
        if (op.lit_be != 4'h0) begin
            chk("lit_byte_en", 32'(cap_be), 32'(op.lit_be));
            chk("lit_wdata",   cap_wd, op.lit_wd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        MemReadIn = 1'b0; MemWriteIn = 1'b0; MemSizeIn = 2'b00; LoadUnsignedIn = 1'b0;
        ALUResultIn = 32'h0; WriteDataIn = 32'h0; RegWriteIn = 1'b1; MemtoRegIn = 1'b1;
        DestinationRegisterIn = 5'd0; bus.MemReady = 1'b0; bus.MemRData = 32'h0;
        m_rdata = 32'h0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_MemReq",    32'(bus.MemReq),    32'h0);
        chk("rst_MemWe",     32'(bus.MemWe),     32'h0);
        chk("rst_MemAddr",   bus.MemAddr,        32'h0);
        chk("rst_MemWData",  bus.MemWData,       32'h0);
        chk("rst_MemByteEn", 32'(bus.MemByteEn), 32'h0);
        chk("rst_ReadData",  ReadDataMemoryOut,  32'h0);
        chk("rst_BusError",  32'(BusError),      32'h0);
        chk("rst_RegWrite",  32'(RegWriteOut),   32'h0);
        chk("rst_MemtoReg",  32'(MemtoRegOut),   32'h0);
        chk("rst_Stall",     32'(Stall),         32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        //         rd wr sz  u addr          wd            rdata         rdy rw dest  req st lit_rd        be       lit_wd        rw berr
        ops.push_back(mk(1,0,2'd0,0,32'h100, 32'h0,        32'hDEADBEEF,1, 1,5'd1, 1,2, 32'hDEADBEEF,4'h0,    32'h0,        1, 0));
        ops.push_back(mk(1,0,2'd2,0,32'h103, 32'h0,        32'h80123456,1, 1,5'd2, 1,2, 32'hFFFFFF80,4'h0,    32'h0,        1, 0));
        ops.push_back(mk(1,0,2'd2,1,32'h103, 32'h0,        32'h80123456,1, 1,5'd3, 1,2, 32'h00000080,4'h0,    32'h0,        1, 0));
        ops.push_back(mk(1,0,2'd1,0,32'h102, 32'h0,        32'h80123456,1, 1,5'd4, 1,2, 32'hFFFF8012,4'h0,    32'h0,        1, 0));
        ops.push_back(mk(1,0,2'd1,1,32'h102, 32'h0,        32'h80123456,2, 1,5'd5, 2,3, 32'h00008012,4'h0,    32'h0,        1, 0));
        ops.push_back(mk(1,0,2'd2,0,32'h101, 32'h0,        32'h80123456,1, 1,5'd6, 1,2, 32'h00000034,4'h0,    32'h0,        1, 0));
        ops.push_back(mk(0,1,2'd2,0,32'h206, 32'h000000A5, 32'h55555555,1, 0,5'd0, 1,2, 32'h00000034,4'b0100, 32'hA5A5A5A5, 0, 0));
        ops.push_back(mk(0,1,2'd1,0,32'h202, 32'h1234BEEF, 32'h55555555,2, 0,5'd0, 2,3, 32'h00000034,4'b1100, 32'hBEEFBEEF, 0, 0));
        ops.push_back(mk(1,1,2'd0,0,32'h300, 32'hCAFEF00D, 32'h99999999,3, 0,5'd0, 3,4, 32'h00000034,4'b1111, 32'hCAFEF00D, 0, 0));
        ops.push_back(mk(1,0,2'd0,0,32'h101, 32'h0,        32'h77777777,0, 1,5'd7, 0,0, 32'h00000034,4'h0,    32'h0,        0, 0));
        ops.push_back(mk(1,0,2'd1,0,32'h103, 32'h0,        32'h77777777,0, 1,5'd8, 0,0, 32'h00000034,4'h0,    32'h0,        0, 0));
        ops.push_back(mk(0,0,2'd0,0,32'h12345678,32'h0,    32'h0,       0, 1,5'd9, 0,0, 32'h00000034,4'h0,    32'h0,        1, 0));
        ops.push_back(mk(1,0,2'd0,0,32'h400, 32'h0,        32'hAAAAAAAA,0, 1,5'd10,4,5, 32'h00000000,4'h0,    32'h0,        0, 1));
        ops.push_back(mk(1,0,2'd0,0,32'h404, 32'h0,        32'h11223344,4, 1,5'd11,4,5, 32'h11223344,4'h0,    32'h0,        1, 0));
        ops.push_back(mk(1,0,2'd1,0,32'h406, 32'h0,        32'h7FFF0000,1, 1,5'd12,1,2, 32'h00007FFF,4'h0,    32'h0,        1, 0));
        ops.push_back(mk(1,0,2'd3,0,32'h500, 32'h0,        32'h0A0B0C0D,1, 1,5'd13,1,2, 32'h0A0B0C0D,4'h0,    32'h0,        1, 0));

        foreach (ops[i]) run_op(ops[i]);
        m_active = 1'b0;

        // Reset during the second REQ cycle of a load that never gets MemReady.
        MemReadIn = 1'b1; MemWriteIn = 1'b0; MemSizeIn = 2'b00; LoadUnsignedIn = 1'b0;
        ALUResultIn = 32'h600; RegWriteIn = 1'b1; MemtoRegIn = 1'b1; DestinationRegisterIn = 5'd14;
        bus.MemRData = 32'h12121212; bus.MemReady = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("rst6_req_before", 32'(bus.MemReq), 32'h1);
        #2 Reset = 1'b1;
        #1;
        chk("rst6_MemReq",   32'(bus.MemReq),  32'h0);
        chk("rst6_Stall",    32'(Stall),       32'h0);
        chk("rst6_ReadData", ReadDataMemoryOut, 32'h0);
        chk("rst6_RegWrite", 32'(RegWriteOut), 32'h0);
        MemReadIn = 1'b0; RegWriteIn = 1'b0; MemtoRegIn = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        bus.MemReady = 1'b1; bus.MemRData = 32'hFFFF_FFFF;
        @(negedge Clk);
        chk("rst6_late_req",   32'(bus.MemReq), 32'h0);
        chk("rst6_late_stall", 32'(Stall),      32'h0);
        @(posedge Clk); #1;
        bus.MemReady = 1'b0;
        chk("rst6_late_rdata",  ReadDataMemoryOut, 32'h0);
        chk("rst6_late_buserr", 32'(BusError),     32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
